score_ctrl: RTL and testbench
=============================

Name: score_ctrl

Overview:
- Downstream consumer of judgement_ctrl. Turns per-note judgement events into a running score, a combo count and a max-combo record.
- Converts the score to BCD with a sequential double-dabble engine and drives a 6-digit multiplexed 7-segment display.
- Game-phase FSM is sequenced by the button_ctrl start/restart pulses and the note_gen game-end flag.

Parameters:
- PTS_PERFECT, 300, base points for a PERFECT judgement.
- PTS_GOOD, 100, base points for a GOOD judgement.
- COMBO_BONUS_TH, 10, combo count at or above which base points are doubled.
- SCORE_MAX, 999999, saturation ceiling for the score.
- COMBO_MAX, 999, saturation ceiling for combo and max combo.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous reset, active-high
- i_tick  in  1  1 ms single-cycle tick from clk_div
- i_start  in  1  debounced start pulse
- i_restart  in  1  debounced restart pulse
- i_game_end  in  1  note_gen end-of-chart flag (level)
- i_judge_valid  in  1  single-cycle strobe, one per judged note
- i_judge  in  2  judgement code, sampled only when i_judge_valid is high
- o_score  out  20  binary score
- o_combo  out  10  current combo
- o_max_combo  out  10  best combo this game
- o_score_bcd  out  24  6-digit BCD score, last completed conversion
- o_seg  out  8  segments {dp,g,f,e,d,c,b,a}, active-high
- o_seg_com  out  6  digit commons, active-low one-hot
- o_playing  out  1  high in PLAY

Behaviour:
- Reset is synchronous and active-high on clk; clk is the only clock. All outputs reset as follows:
  - o_score, o_combo, o_max_combo, o_score_bcd, o_seg = 0
  - o_seg_com = 6'b111110 (digit 0 selected)
  - o_playing = 0
  - FSM = IDLE
- Judge codes: 00 NONE, 01 MISS, 10 GOOD, 11 PERFECT. A valid strobe with NONE is ignored.
- FSM states IDLE, PLAY, DONE:
  - IDLE→PLAY on i_start. Score, combo, max combo and all counters clear in the same edge.
  - PLAY→DONE on i_game_end.
  - PLAY→IDLE on i_restart, which clears everything.
  - DONE→IDLE on i_restart, which clears everything.
  - i_start in PLAY or DONE is ignored.
- Judge events are accepted only in PLAY. In IDLE and DONE they are dropped.
- Scoring takes 1 cycle: o_score, o_combo and o_max_combo update on the edge after the strobe.
  - PERFECT/GOOD: combo = min(combo+1, COMBO_MAX). Points = base, or base×2 if the pre-increment combo ≥ COMBO_BONUS_TH.
  - MISS: combo = 0, no points.
  - Score saturates at SCORE_MAX; no wrap.
  - max_combo = max(max_combo, new combo), updated in the same cycle.
- Simultaneous events:
  - Judge strobe and i_game_end in the same cycle in PLAY: the judge is counted, then the FSM enters DONE.
  - i_restart and a judge in the same cycle: restart wins and the judge is dropped.
- BCD engine (sub-module):
  - Starts the cycle after any o_score change, including a clear.
  - 20 shift/add-3 iterations, one per cycle. o_score_bcd is latched on completion, 21 cycles after start.
  - If the score changes while busy, a pending flag is set and one reconversion of the latest score runs immediately after completion. o_score_bcd never shows a partial result.
- Display scan:
  - On each i_tick, advance the digit index 0→5→0 (wraps).
  - o_seg_com is low only for the current index. o_seg decodes nibble [4*idx+3 : 4*idx] of o_score_bcd; digit 0 is the LSD.
  - dp is lit on digit 0 only while o_playing.
  - Non-BCD nibbles (unreachable) decode to all-off.
  - Outputs are registered and change one cycle after the tick.

Decomposition:
- Shared package holds:
  - judge code constants (JUDGE_NONE/MISS/GOOD/PERFECT), shared with judgement_ctrl;
  - FSM state encoding;
  - 7-segment digit lookup constants (0–9, blank).
- One sub-module, bin2bcd_seq:
  - ports: start, 20-bit bin, busy, done pulse, 24-bit bcd;
  - implements the iterative double-dabble.
- Scoring, FSM and scan stay in score_ctrl.

Test Plan:
- Reset, then i_start, then 3 PERFECT strobes → o_score=900, o_combo=3, o_max_combo=3. o_score_bcd=0x000900 within 22 cycles of the last update.
- 10 GOOD then 1 PERFECT → after the 10th GOOD score=1000. The 11th judgement is doubled, so score=1600, combo=11.
- 5 GOOD, MISS, 2 GOOD → combo=2, max_combo=5, score=700.
- Two PERFECT strobes 3 cycles apart → BCD pending path runs and final o_score_bcd=0x000600. No intermediate non-BCD value appears.
- Judge strobe with i_game_end in the same cycle → counted, FSM=DONE, o_playing=0. A further strobe changes nothing. i_restart → all zeros, IDLE.
- Preload near SCORE_MAX (999900 via strobes) plus one doubled PERFECT → o_score=999999. Over 6 ticks o_seg_com cycles 111110→011111 and o_seg shows "9" on each digit.

Source files
------------

// File: rtl/score_ctrl_pkg.sv
// Shared constants for the scoring path: judgement codes, game-phase encoding
// and 7-segment glyphs ({g,f,e,d,c,b,a}, active-high).
package score_ctrl_pkg;

  localparam logic [1:0] JUDGE_NONE    = 2'b00;
  localparam logic [1:0] JUDGE_MISS    = 2'b01;
  localparam logic [1:0] JUDGE_GOOD    = 2'b10;
  localparam logic [1:0] JUDGE_PERFECT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } game_state_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = SEG_0;
      4'd1:    seg_decode = SEG_1;
      4'd2:    seg_decode = SEG_2;
      4'd3:    seg_decode = SEG_3;
      4'd4:    seg_decode = SEG_4;
      4'd5:    seg_decode = SEG_5;
      4'd6:    seg_decode = SEG_6;
      4'd7:    seg_decode = SEG_7;
      4'd8:    seg_decode = SEG_8;
      4'd9:    seg_decode = SEG_9;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/score_ctrl_bin2bcd_seq.sv
// Iterative double-dabble: 20-bit binary to 6 BCD digits, one bit per cycle.
// o_bcd is only meaningful while o_done is high.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [19:0] i_bin,
  output logic        o_busy,
  output logic        o_done,
  output logic [23:0] o_bcd
);

  logic [19:0] r_bin;
  logic [23:0] r_bcd;
  logic [4:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic [23:0] w_adj;
  logic [43:0] w_shift;

  // Add 3 to every digit of 5 or more before each shift.
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 6; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
    w_shift = {w_adj, r_bin} << 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!r_busy) begin
        if (i_start) begin
          r_bin  <= i_bin;
          r_bcd  <= '0;
          r_cnt  <= '0;
          r_busy <= 1'b1;
        end
      end else begin
        r_bcd <= w_shift[43:20];
        r_bin <= w_shift[19:0];
        r_cnt <= r_cnt + 5'd1;
        if (r_cnt == 5'd19) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/score_ctrl.sv
// Game scoring: phase FSM, per-judgement score/combo update, BCD conversion
// scheduling and a 6-digit multiplexed 7-segment scan.
module score_ctrl
  import score_ctrl_pkg::*;
#(
  parameter int PTS_PERFECT    = 300,
  parameter int PTS_GOOD       = 100,
  parameter int COMBO_BONUS_TH = 10,
  parameter int SCORE_MAX      = 999999,
  parameter int COMBO_MAX      = 999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_tick,
  input  logic        i_start,
  input  logic        i_restart,
  input  logic        i_game_end,
  input  logic        i_judge_valid,
  input  logic [1:0]  i_judge,
  output logic [19:0] o_score,
  output logic [9:0]  o_combo,
  output logic [9:0]  o_max_combo,
  output logic [23:0] o_score_bcd,
  output logic [7:0]  o_seg,
  output logic [5:0]  o_seg_com,
  output logic        o_playing
);

  game_state_t r_state, w_state_nxt;
  logic        w_playing, w_clear, w_accept;

  logic [19:0] r_score, r_score_d;
  logic [9:0]  r_combo, r_max_combo;
  logic [19:0] w_base, w_pts, w_score_nxt;
  logic [20:0] w_sum;
  logic [9:0]  w_combo_nxt;

  logic        w_score_chg, w_bcd_kick, w_bcd_busy, w_bcd_done;
  logic        r_bcd_pend;
  logic [23:0] w_bcd;
  logic [23:0] r_score_bcd;

  logic [2:0]  r_idx;
  logic [3:0]  w_nib;
  logic [7:0]  r_seg;
  logic [5:0]  r_com;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_state_nxt = ST_PLAY;
      ST_PLAY: begin
        if (i_restart)       w_state_nxt = ST_IDLE;
        else if (i_game_end) w_state_nxt = ST_DONE;
      end
      ST_DONE: if (i_restart) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // i_judge_valid is a one-cycle strobe with no backpressure: it is consumed
  // only in PLAY and is dropped when a restart arrives in the same cycle.
  always_comb begin
    w_playing = (r_state == ST_PLAY);
    w_clear   = ((r_state == ST_IDLE) && i_start) ||
                ((r_state != ST_IDLE) && i_restart);
    w_accept  = w_playing && !i_restart && i_judge_valid && (i_judge != JUDGE_NONE);
  end

  always_comb begin
    w_base      = (i_judge == JUDGE_PERFECT) ? 20'(PTS_PERFECT) : 20'(PTS_GOOD);
    w_pts       = (r_combo >= 10'(COMBO_BONUS_TH)) ? (w_base << 1) : w_base;
    w_sum       = {1'b0, r_score} + {1'b0, w_pts};
    w_score_nxt = (w_sum > 21'(SCORE_MAX)) ? 20'(SCORE_MAX) : w_sum[19:0];
    w_combo_nxt = (r_combo >= 10'(COMBO_MAX)) ? 10'(COMBO_MAX) : (r_combo + 10'd1);
  end

  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_score     <= '0;
      r_combo     <= '0;
      r_max_combo <= '0;
    end else if (w_accept) begin
      if (i_judge == JUDGE_MISS) begin
        r_combo <= '0;
      end else begin
        r_score <= w_score_nxt;
        r_combo <= w_combo_nxt;
        if (w_combo_nxt > r_max_combo) r_max_combo <= w_combo_nxt;
      end
    end
  end

  // A score change while the converter is busy is remembered and replayed
  // with whatever the score is once the converter frees up.
  assign w_score_chg = (r_score != r_score_d);
  assign w_bcd_kick  = (w_score_chg || r_bcd_pend) && !w_bcd_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_score_d   <= '0;
      r_bcd_pend  <= 1'b0;
      r_score_bcd <= '0;
    end else begin
      r_score_d <= r_score;
      if (w_bcd_kick)       r_bcd_pend <= 1'b0;
      else if (w_score_chg) r_bcd_pend <= 1'b1;
      if (w_bcd_done) r_score_bcd <= w_bcd;
    end
  end

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_bcd_kick),
    .i_bin   (r_score),
    .o_busy  (w_bcd_busy),
    .o_done  (w_bcd_done),
    .o_bcd   (w_bcd)
  );

  always_comb begin
    case (r_idx)
      3'd0:    w_nib = r_score_bcd[3:0];
      3'd1:    w_nib = r_score_bcd[7:4];
      3'd2:    w_nib = r_score_bcd[11:8];
      3'd3:    w_nib = r_score_bcd[15:12];
      3'd4:    w_nib = r_score_bcd[19:16];
      3'd5:    w_nib = r_score_bcd[23:20];
      default: w_nib = 4'hF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= '0;
      r_seg <= '0;
      r_com <= 6'b111110;
    end else begin
      if (i_tick) r_idx <= (r_idx == 3'd5) ? 3'd0 : (r_idx + 3'd1);
      r_seg <= {w_playing && (r_idx == 3'd0), seg_decode(w_nib)};
      r_com <= ~(6'd1 << r_idx);
    end
  end

  assign o_score     = r_score;
  assign o_combo     = r_combo;
  assign o_max_combo = r_max_combo;
  assign o_score_bcd = r_score_bcd;
  assign o_seg       = r_seg;
  assign o_seg_com   = r_com;
  assign o_playing   = w_playing;

endmodule

// File: tb/tb_score_ctrl.sv
// Bench for score_ctrl: directed scenarios plus random judgement streams,
// checked against a game-rule model through an expected-value queue.
module tb_score_ctrl;
  import score_ctrl_pkg::*;

  logic        clk, rst;
  logic        i_tick, i_start, i_restart, i_game_end, i_judge_valid;
  logic [1:0]  i_judge;
  logic [19:0] o_score;
  logic [9:0]  o_combo, o_max_combo;
  logic [23:0] o_score_bcd;
  logic [7:0]  o_seg;
  logic [5:0]  o_seg_com;
  logic        o_playing;

  score_ctrl dut (
    .clk(clk), .rst(rst), .i_tick(i_tick), .i_start(i_start),
    .i_restart(i_restart), .i_game_end(i_game_end),
    .i_judge_valid(i_judge_valid), .i_judge(i_judge),
    .o_score(o_score), .o_combo(o_combo), .o_max_combo(o_max_combo),
    .o_score_bcd(o_score_bcd), .o_seg(o_seg), .o_seg_com(o_seg_com),
    .o_playing(o_playing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit bad_nib = 1'b0;
  logic [39:0] exp_q[$];

  // Reference game: 0 idle, 1 playing, 2 finished.
  int m_state = 0;
  int m_score = 0;
  int m_combo = 0;
  int m_max   = 0;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic model_clear();
    m_score = 0;
    m_combo = 0;
    m_max   = 0;
  endtask

  task automatic model_step(input bit st, input bit rs, input bit ge, input bit jv,
                            input logic [1:0] jc);
    int pts;
    if (m_state == 0) begin
      if (st) begin model_clear(); m_state = 1; end
    end else if (m_state == 1) begin
      if (rs) begin
        model_clear(); m_state = 0;
      end else begin
        if (jv && jc == JUDGE_MISS) m_combo = 0;
        else if (jv && jc != JUDGE_NONE) begin
          pts = (jc == JUDGE_PERFECT) ? 300 : 100;
          if (m_combo >= 10) pts = pts * 2;
          m_score = (m_score + pts > 999999) ? 999999 : m_score + pts;
          m_combo = (m_combo + 1 > 999) ? 999 : m_combo + 1;
          if (m_combo > m_max) m_max = m_combo;
        end
        if (ge) m_state = 2;
      end
    end else begin
      if (rs) begin model_clear(); m_state = 0; end
    end
  endtask

  task automatic cyc(input bit st, input bit rs, input bit ge, input bit jv,
                     input logic [1:0] jc, input bit tk);
    @(negedge clk);
    i_start = st; i_restart = rs; i_game_end = ge;
    i_judge_valid = jv; i_judge = jc; i_tick = tk;
    model_step(st, rs, ge, jv, jc);
    if (jv) exp_q.push_back({20'(m_score), 10'(m_combo), 10'(m_max)});
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, JUDGE_NONE, 1'b0);
  endtask

  task automatic judge(input logic [1:0] jc);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, jc, 1'b0);
  endtask

  task automatic restart_start();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, JUDGE_NONE, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, JUDGE_NONE, 1'b0);
    idle(1);
  endtask

  task automatic wait_bcd(input string name, input int bound);
    logic [23:0] e;
    e = to_bcd(m_score);
    for (int i = 0; i < bound; i++) begin
      idle(1);
      if (o_score_bcd == e) break;
    end
    check(name, 40'(o_score_bcd), 40'(e));
  endtask

  always @(posedge clk) begin : monitor
    logic        v;
    logic [39:0] e;
    v = i_judge_valid && !rst;
    #1;
    if (v) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 40'(1), 40'(0));
      end else begin
        e = exp_q.pop_front();
        check("sb_score", 40'(o_score), 40'(e[39:20]));
        check("sb_combo", 40'(o_combo), 40'(e[19:10]));
        check("sb_max_combo", 40'(o_max_combo), 40'(e[9:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 6; i++)
        if (o_score_bcd[4*i +: 4] > 4'd9) bad_nib = 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ec;
    rst = 1'b1;
    i_tick = 0; i_start = 0; i_restart = 0; i_game_end = 0;
    i_judge_valid = 0; i_judge = JUDGE_NONE;
    repeat (3) @(negedge clk);
    check("rst_score", 40'(o_score), 40'(0));
    check("rst_combo", 40'(o_combo), 40'(0));
    check("rst_max", 40'(o_max_combo), 40'(0));
    check("rst_bcd", 40'(o_score_bcd), 40'(0));
    check("rst_seg", 40'(o_seg), 40'(0));
    check("rst_seg_com", 40'(o_seg_com), 40'(6'b111110));
    check("rst_playing", 40'(o_playing), 40'(0));
    rst = 1'b0;

    // Three spaced PERFECTs
    cyc(1'b1, 1'b0, 1'b0, 1'b0, JUDGE_NONE, 1'b0);
    idle(1);
    check("t1_playing", 40'(o_playing), 40'(1));
    judge(JUDGE_PERFECT); idle(24);
    judge(JUDGE_PERFECT); idle(24);
    judge(JUDGE_PERFECT);
    wait_bcd("t1_bcd_latency", 23);
    check("t1_bcd_900", 40'(o_score_bcd), 40'(24'h000900));
    check("t1_score", 40'(o_score), 40'(900));
    check("t1_combo", 40'(o_combo), 40'(3));
    check("t1_max", 40'(o_max_combo), 40'(3));

    // Combo bonus threshold
    restart_start();
    repeat (10) judge(JUDGE_GOOD);
    idle(1);
    check("t2_score_1000", 40'(o_score), 40'(1000));
    judge(JUDGE_PERFECT);
    idle(1);
    check("t2_score_1600", 40'(o_score), 40'(1600));
    check("t2_combo_11", 40'(o_combo), 40'(11));

    // MISS breaks combo, max retained; restart beats a judge
    restart_start();
    repeat (5) judge(JUDGE_GOOD);
    judge(JUDGE_MISS);
    repeat (2) judge(JUDGE_GOOD);
    idle(1);
    check("t3_score", 40'(o_score), 40'(700));
    check("t3_combo", 40'(o_combo), 40'(2));
    check("t3_max", 40'(o_max_combo), 40'(5));
    cyc(1'b0, 1'b1, 1'b0, 1'b1, JUDGE_PERFECT, 1'b0);
    idle(1);
    check("t3_restart_score", 40'(o_score), 40'(0));
    check("t3_restart_idle", 40'(o_playing), 40'(0));

    // Two PERFECTs three cycles apart
    cyc(1'b1, 1'b0, 1'b0, 1'b0, JUDGE_NONE, 1'b0);
    idle(1);
    judge(JUDGE_PERFECT); idle(2);
    judge(JUDGE_PERFECT);
    wait_bcd("t4_bcd", 80);
    check("t4_bcd_600", 40'(o_score_bcd), 40'(24'h000600));

    // Judge together with game end, then DONE behaviour
    cyc(1'b0, 1'b0, 1'b1, 1'b1, JUDGE_GOOD, 1'b0);
    idle(1);
    check("t5_done_playing", 40'(o_playing), 40'(0));
    check("t5_counted", 40'(o_score), 40'(700));
    judge(JUDGE_PERFECT);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, JUDGE_NONE, 1'b0);
    idle(1);
    check("t5_start_ignored", 40'(o_playing), 40'(0));
    cyc(1'b0, 1'b1, 1'b0, 1'b0, JUDGE_NONE, 1'b0);
    idle(1);
    check("t5_clr_score", 40'(o_score), 40'(0));
    check("t5_clr_combo", 40'(o_combo), 40'(0));
    check("t5_clr_max", 40'(o_max_combo), 40'(0));
    check("t5_idle", 40'(o_playing), 40'(0));
    wait_bcd("t5_bcd_clear", 80);

    // Random judgement stream
    cyc(1'b1, 1'b0, 1'b0, 1'b0, JUDGE_NONE, 1'b0);
    for (int n = 0; n < 300; n++) begin
      cyc(($urandom_range(0, 7) == 0), 1'b0, 1'b0, 1'b1,
          2'($urandom_range(0, 3)), 1'b0);
      idle($urandom_range(0, 2));
    end
    wait_bcd("rand_bcd", 80);

    // Saturation and display scan
    restart_start();
    judge(JUDGE_GOOD);
    judge(JUDGE_MISS);
    repeat (10) judge(JUDGE_GOOD);
    repeat (1664) judge(JUDGE_PERFECT);
    repeat (2) judge(JUDGE_GOOD);
    idle(2);
    check("t7_preload", 40'(o_score), 40'(999900));
    judge(JUDGE_PERFECT);
    idle(1);
    check("t7_sat_score", 40'(o_score), 40'(999999));
    check("t7_sat_combo", 40'(o_combo), 40'(999));
    wait_bcd("t7_bcd", 80);
    idle(1);
    check("scan_com_0", 40'(o_seg_com), 40'(6'b111110));
    check("scan_seg_0", 40'(o_seg), 40'(8'hEF));
    for (int k = 1; k <= 6; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, JUDGE_NONE, 1'b1);
      idle(1);
      if (k == 1) check("scan_com_lag", 40'(o_seg_com), 40'(6'b111110));
      idle(1);
      ec = 6'b111111;
      ec[k % 6] = 1'b0;
      check("scan_com", 40'(o_seg_com), 40'(ec));
      check("scan_seg", 40'(o_seg), 40'((k % 6 == 0) ? 8'hEF : 8'h6F));
    end

    idle(2);
    check("bcd_digits_valid", 40'(bad_nib), 40'(0));
    check("sb_drained", 40'(exp_q.size()), 40'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
